icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, VIPT instruction cache directly downstream of the CPU fetch stages.
//  Fetch1 drives the request (idx/op/pa/is_cached); one cycle later Fetch2 samples ready/data.
//  Misses refill a full line and uncached fetches do a single-word read, both over a simple
//  burst read port toward the AXI bridge. Also executes CACOP index/hit invalidate ops.
// PARAMETERS
//  SETS        256  lines; SETS*LINE_WORDS*4 must equal 4096 (index fits in page offset)
//  LINE_WORDS  4    32-bit words per line; set = idx[11:OFS], word = idx[OFS-1:2]
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous, active-high reset
//  is_icache_stall  in   1   pipeline stall; hold response, accept no new request
//  icache_idx       in   12  VA page offset of request
//  icache_op        in   3   ICOP_NOP/FETCH/IDX_INIT/IDX_INV/HIT_INV (icache_pkg)
//  icache_is_cached in   1   1 = cacheable fetch
//  icache_pa        in   32  physical address, same cycle as idx
//  icache_ready     out  1   response valid (data or cacop done)
//  icache_data      out  32  instruction word
//  mem_rd_req       out  1   read request, held until mem_rd_gnt
//  mem_rd_addr      out  32  line-aligned (burst) or word address
//  mem_rd_burst     out  1   1 = LINE_WORDS beats, 0 = single beat
//  mem_rd_gnt       in   1   request accepted
//  mem_rd_valid     in   1   data beat valid
//  mem_rd_data      in   32  beat data, ascending word order
//  mem_rd_last      in   1   final beat
// BEHAVIOUR
//  Reset: all valid bits 0, state IDLE, icache_ready=0, icache_data=0, mem_rd_req=0,
//   mem_rd_addr=0, mem_rd_burst=0; refill counter 0. Reset mid-refill abandons the refill.
//  Accept: op!=NOP, state IDLE, !is_icache_stall, and no held response -> latch req into
//   stage-2 regs; tag/valid/data arrays read synchronously with idx (1-cycle read).
//  Hit (FETCH, cached, valid && tag==pa[31:12]): ready=1 with data the next cycle; back-to-back
//   hits give one ready per cycle.
//  FSM IDLE -> MISS_REQ (cached miss, burst=1, addr=pa & ~(LINE_WORDS*4-1)) or
//   UNC_REQ (uncached, burst=0, addr=pa); REQ -> WAIT on mem_rd_gnt (req drops same edge).
//  REFILL: each beat writes data[set][cnt], cnt++ (wraps to 0); on mem_rd_last write
//   tag, set valid, go REPLAY; REPLAY re-reads arrays -> IDLE and ready=1 next cycle.
//  UNC_WAIT: first mem_rd_valid -> ready=1, data=mem_rd_data next cycle, no array write.
//  IDX_INIT/IDX_INV: clear valid[set] regardless of pa; HIT_INV: clear only on tag match;
//   ready=1 one cycle after accept, data=0.
//  Stall: if is_icache_stall while ready=1, ready/data held stable until stall low; ready
//   drops after the first non-stalled cycle unless a new hit was accepted that cycle.
//  Stall during MISS/REFILL does not pause memory traffic; response held on completion.
//  Refill to set S while a held request targets S: the REPLAY read reflects the new line.
//  mem_rd_valid outside REFILL/UNC_WAIT is ignored (assertion in sim).
// STRUCTURE
//  icache_pkg: icache_op_t enum (NOP=0,FETCH=1,IDX_INIT=2,IDX_INV=3,HIT_INV=4),
//   icache_state_t, tag width 20, line offset/index widths derived from parameters.
//  One sub-module: icache_sram (1R1W sync-read array, param WIDTH/DEPTH), instantiated for
//   data (per word) and tag; valid bits kept in flops for single-cycle reset clear.
// TESTING
//  Cold FETCH pa=0x1C000000 cached -> burst req addr 0x1C000000, 4 beats, ready+data=beat0.
//  Repeat FETCH idx 0x004 same line -> ready next cycle, data=beat1, no mem_rd_req.
//  Uncached FETCH pa=0x1FD00010 -> burst=0 single req, ready with mem word, array unchanged.
//  Hit with is_icache_stall high 3 cycles -> ready/data stable 3 cycles, then one more only.
//  HIT_INV on cached line then FETCH -> ready for cacop, then refill re-issued (miss).
//  rst asserted mid-refill after beat 2 -> all outputs reset, line stays invalid, next
//   FETCH misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped VIPT instruction cache.
// Set index plus line offset span the 4 KiB page offset, so idx selects the set before translation.
package icache_pkg;

  localparam int SETS       = 256;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;
  localparam int OFS        = $clog2(LINE_BYTES);
  localparam int SET_W      = $clog2(SETS);
  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int TAG_W      = 20;

  typedef enum logic [2:0] {
    ICOP_NOP      = 3'd0,
    ICOP_FETCH    = 3'd1,
    ICOP_IDX_INIT = 3'd2,
    ICOP_IDX_INV  = 3'd3,
    ICOP_HIT_INV  = 3'd4
  } icache_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS_REQ,
    S_REFILL,
    S_UNC_REQ,
    S_UNC_WAIT,
    S_REPLAY
  } icache_state_t;

  function automatic logic [31:0] line_base(input logic [31:0] pa);
    return pa & ~(32'(LINE_BYTES) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_sram.sv
// Purpose: 1R1W synchronous-read array used for cache tags and data words.
// Latency: read data appears one cycle after re; write lands on the clock edge.
// Backpressure: none; rdata holds its last value while re is low.
module icache_sram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/icache_direct.sv
// Purpose: direct-mapped VIPT icache between fetch stages and a burst read port; runs CACOPs.
// Latency: hit/CACOP respond the cycle after accept; misses refill, replay, then respond.
// Backpressure: is_icache_stall blocks accept and freezes a presented response.
module icache_direct
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        is_icache_stall,
  input  logic [11:0] icache_idx,
  input  logic [2:0]  icache_op,
  input  logic        icache_is_cached,
  input  logic [31:0] icache_pa,
  output logic        icache_ready,
  output logic [31:0] icache_data,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_burst,
  input  logic        mem_rd_gnt,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_last
);

  icache_state_t     state, state_nxt;
  logic              s2_vld, s2_cached, unc_done;
  icache_op_t        s2_op;
  logic [31:0]       s2_pa, unc_dat;
  logic [SET_W-1:0]  s2_set, rd_set;
  logic [WORD_W-1:0] s2_word, cnt;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       word_q [LINE_WORDS];
  logic              unused_idx;

  assign unused_idx = ^icache_idx[1:0];

  logic in_idle, is_fetch, is_cacop, tag_hit, rsp, consume, acc;
  logic miss, unc_go, inv, refill_beat, rd_en;

  assign in_idle  = (state == S_IDLE);
  assign is_fetch = (s2_op == ICOP_FETCH);
  assign is_cacop = s2_op inside {ICOP_IDX_INIT, ICOP_IDX_INV, ICOP_HIT_INV};
  // valid comes from flops, so an invalidate or refill to this set is seen immediately
  assign tag_hit  = valid_q[s2_set] && (tag_q == s2_pa[31:12]);
  assign rsp      = s2_vld && in_idle &&
                    (is_cacop || (is_fetch && (s2_cached ? tag_hit : unc_done)));
  assign consume  = rsp && !is_icache_stall;
  assign acc      = (icache_op inside {3'd1, 3'd2, 3'd3, 3'd4}) && in_idle &&
                    !is_icache_stall && (!s2_vld || rsp);
  assign miss     = s2_vld && in_idle && is_fetch && s2_cached && !tag_hit;
  assign unc_go   = s2_vld && in_idle && is_fetch && !s2_cached && !unc_done;
  assign inv      = s2_vld && in_idle && is_cacop && (s2_op != ICOP_HIT_INV || tag_hit);
  assign refill_beat = (state == S_REFILL) && mem_rd_valid;

  // REPLAY re-reads the held set so the response sees the freshly written line
  assign rd_en  = acc || (state == S_REPLAY);
  assign rd_set = (state == S_REPLAY) ? s2_set : icache_idx[11:OFS];

  icache_sram #(.WIDTH(TAG_W), .DEPTH(SETS)) u_tag (
    .clk(clk), .we(refill_beat && mem_rd_last), .waddr(s2_set), .wdata(s2_pa[31:12]),
    .re(rd_en), .raddr(rd_set), .rdata(tag_q)
  );

  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_data
    icache_sram #(.WIDTH(32), .DEPTH(SETS)) u_data (
      .clk(clk), .we(refill_beat && (cnt == WORD_W'(w))), .waddr(s2_set), .wdata(mem_rd_data),
      .re(rd_en), .raddr(rd_set), .rdata(word_q[w])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (miss) state_nxt = S_MISS_REQ;
                  else if (unc_go) state_nxt = S_UNC_REQ;
      S_MISS_REQ: if (mem_rd_gnt) state_nxt = S_REFILL;
      S_REFILL:   if (mem_rd_valid && mem_rd_last) state_nxt = S_REPLAY;
      S_UNC_REQ:  if (mem_rd_gnt) state_nxt = S_UNC_WAIT;
      S_UNC_WAIT: if (mem_rd_valid) state_nxt = S_IDLE;
      S_REPLAY:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      s2_vld       <= 1'b0;
      s2_op        <= ICOP_NOP;
      s2_pa        <= '0;
      s2_cached    <= 1'b0;
      s2_set       <= '0;
      s2_word      <= '0;
      unc_done     <= 1'b0;
      unc_dat      <= '0;
      valid_q      <= '0;
      cnt          <= '0;
      mem_rd_addr  <= '0;
      mem_rd_burst <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        s2_vld    <= 1'b1;
        s2_op     <= icache_op_t'(icache_op);
        s2_pa     <= icache_pa;
        s2_cached <= icache_is_cached;
        s2_set    <= icache_idx[11:OFS];
        s2_word   <= icache_idx[OFS-1:2];
      end else if (consume) begin
        s2_vld <= 1'b0;
      end
      if (consume) begin
        unc_done <= 1'b0;
      end else if (state == S_UNC_WAIT && mem_rd_valid) begin
        unc_done <= 1'b1;
        unc_dat  <= mem_rd_data;
      end
      if (refill_beat) cnt <= cnt + WORD_W'(1);
      if (inv) valid_q[s2_set] <= 1'b0;
      if (refill_beat && mem_rd_last) valid_q[s2_set] <= 1'b1;
      if (miss) begin
        mem_rd_addr  <= line_base(s2_pa);
        mem_rd_burst <= 1'b1;
      end else if (unc_go) begin
        mem_rd_addr  <= s2_pa;
        mem_rd_burst <= 1'b0;
      end
    end
  end

  assign mem_rd_req   = (state == S_MISS_REQ) || (state == S_UNC_REQ);
  assign icache_ready = rsp;
  assign icache_data  = !rsp     ? 32'd0 :
                        is_cacop ? 32'd0 :
                        s2_cached ? word_q[s2_word] : unc_dat;

  a_rd_valid_in_window: assert property (@(posedge clk) disable iff (rst)
    mem_rd_valid |-> (state == S_REFILL || state == S_UNC_WAIT));

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a set-level cache model plus an expected-response queue,
// a burst memory responder, and a negedge checker comparing ready/data and read requests.
module tb_icache_direct;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_icache_stall = 1'b0;
  logic [11:0] icache_idx = '0;
  logic [2:0]  icache_op = '0;
  logic        icache_is_cached = 1'b0;
  logic [31:0] icache_pa = '0;
  logic        icache_ready;
  logic [31:0] icache_data;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_burst;
  logic        mem_rd_gnt = 1'b0;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        mem_rd_last = 1'b0;

  int vec = 0;
  int errs = 0;

  // model state
  bit          mvalid [256];
  logic [19:0] mtag   [256];
  logic [31:0] exp_q [$];
  bit          mreq_exp = 1'b0;
  logic [31:0] mreq_addr = '0;
  bit          mreq_burst = 1'b0;

  // responder state
  int          gnt_cnt = 0;
  int          beats_sent = 0;
  int          beat_limit = 4;
  logic [31:0] last_gnt_addr = '0;

  always #5 clk = ~clk;

  icache_direct dut (
    .clk(clk), .rst(rst), .is_icache_stall(is_icache_stall),
    .icache_idx(icache_idx), .icache_op(icache_op), .icache_is_cached(icache_is_cached),
    .icache_pa(icache_pa), .icache_ready(icache_ready), .icache_data(icache_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_burst(mem_rd_burst),
    .mem_rd_gnt(mem_rd_gnt), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_rd_last(mem_rd_last)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // checker: every presented response and every read request against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (icache_ready) begin
        if (exp_q.size() == 0) chk("spurious_ready", 32'(icache_ready), 32'd0);
        else begin
          chk("rsp_data", icache_data, exp_q[0]);
          if (!is_icache_stall) void'(exp_q.pop_front());
        end
      end
      if (mem_rd_req) begin
        chk("mreq_allowed", 32'(mreq_exp), 32'd1);
        chk("mreq_addr", mem_rd_addr, mreq_addr);
        chk("mreq_burst", 32'(mem_rd_burst), 32'(mreq_burst));
      end
    end
  end

  // memory: grant one cycle after request, then ascending beats (optionally truncated)
  initial begin
    logic [31:0] a;
    int n;
    forever begin
      @(posedge clk); #1;
      if (mem_rd_req && !rst) begin
        a = mem_rd_addr;
        n = mem_rd_burst ? 4 : 1;
        mem_rd_gnt = 1'b1;
        @(posedge clk); #1;
        mem_rd_gnt = 1'b0;
        gnt_cnt++;
        last_gnt_addr = a;
        for (int i = 0; i < n && i < beat_limit; i++) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem_word(a + 32'(4 * i));
          mem_rd_last  = (i == n - 1);
          @(posedge clk); #1;
          beats_sent++;
        end
        mem_rd_valid = 1'b0;
        mem_rd_last  = 1'b0;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(icache_ready), 32'd0);
    chk({tag, "_data"}, icache_data, 32'd0);
    chk({tag, "_req"}, 32'(mem_rd_req), 32'd0);
    chk({tag, "_addr"}, mem_rd_addr, 32'd0);
    chk({tag, "_burst"}, 32'(mem_rd_burst), 32'd0);
  endtask

  // one request: predict from the model, drive for one cycle, wait for the response
  task automatic issue(input logic [2:0] op, input logic [11:0] idx, input logic [31:0] pa,
                       input bit cached, input int stall_cyc, input string name,
                       output logic [31:0] got);
    int set, lat, g0, nrdy;
    bit seen, miss;
    logic [31:0] ed;
    set = int'(idx[11:4]);
    ed = '0;
    miss = 1'b0;
    if (op == ICOP_FETCH) begin
      ed = mem_word(cached ? {pa[31:4], idx[3:2], 2'b00} : pa);
      if (!cached) begin
        miss = 1'b1; mreq_addr = pa; mreq_burst = 1'b0;
      end else if (!(mvalid[set] && mtag[set] == pa[31:12])) begin
        miss = 1'b1; mreq_addr = {pa[31:4], 4'h0}; mreq_burst = 1'b1;
        mvalid[set] = 1'b1; mtag[set] = pa[31:12];
      end
    end else if (op == ICOP_IDX_INIT || op == ICOP_IDX_INV) begin
      mvalid[set] = 1'b0;
    end else if (op == ICOP_HIT_INV && mvalid[set] && mtag[set] == pa[31:12]) begin
      mvalid[set] = 1'b0;
    end
    mreq_exp = miss;
    exp_q.push_back(ed);
    g0 = gnt_cnt;
    icache_op = op; icache_idx = idx; icache_pa = pa; icache_is_cached = cached;
    @(posedge clk); #1;
    icache_op = '0;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (icache_ready) seen = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    got = icache_data;
    chk({name, "_ready_seen"}, 32'(seen), 32'd1);
    chk({name, "_went_to_mem"}, 32'(lat > 0), 32'(miss));
    nrdy = 0;
    if (stall_cyc > 0) begin
      is_icache_stall = 1'b1;
      for (int i = 0; i < stall_cyc; i++) begin
        nrdy += int'(icache_ready);
        @(posedge clk); #1;
      end
      is_icache_stall = 1'b0;
    end
    nrdy += int'(icache_ready);
    @(posedge clk); #1;
    chk({name, "_ready_cycles"}, 32'(nrdy), 32'(stall_cyc + 1));
    chk({name, "_ready_drop"}, 32'(icache_ready), 32'd0);
    chk({name, "_mem_trips"}, 32'(gnt_cnt - g0), 32'(miss));
    mreq_exp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int b0, nrdy, t;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;
    @(posedge clk); #1;

    issue(ICOP_FETCH, 12'h000, 32'h1C00_0000, 1'b1, 0, "cold_miss", got);
    chk("cold_miss_lit_data", got, 32'hC2AD_BEEF);
    chk("cold_miss_lit_addr", last_gnt_addr, 32'h1C00_0000);
    issue(ICOP_FETCH, 12'h004, 32'h1C00_0004, 1'b1, 0, "hit_w1", got);
    chk("hit_w1_lit_data", got, 32'hC2AD_BEEB);
    issue(ICOP_FETCH, 12'h010, 32'h1FD0_0010, 1'b0, 0, "uncached", got);
    chk("uncached_lit_data", got, 32'hC17D_BEFF);
    chk("uncached_lit_addr", last_gnt_addr, 32'h1FD0_0010);
    issue(ICOP_FETCH, 12'h010, 32'h1FD0_0010, 1'b1, 0, "after_unc_miss", got);
    issue(ICOP_FETCH, 12'h00C, 32'h1C00_000C, 1'b1, 0, "hit_w3", got);
    issue(ICOP_FETCH, 12'h008, 32'h1C00_0008, 1'b1, 3, "stall_hit", got);

    // back-to-back hits in two different sets
    exp_q.push_back(mem_word(32'h1C00_0004));
    exp_q.push_back(mem_word(32'h1FD0_0014));
    icache_op = ICOP_FETCH; icache_is_cached = 1'b1;
    icache_idx = 12'h004; icache_pa = 32'h1C00_0004;
    @(posedge clk); #1;
    icache_idx = 12'h014; icache_pa = 32'h1FD0_0014;
    nrdy = int'(icache_ready);
    @(posedge clk); #1;
    icache_op = ICOP_NOP;
    nrdy += int'(icache_ready);
    @(posedge clk); #1;
    chk("b2b_ready_cycles", 32'(nrdy), 32'd2);
    chk("b2b_ready_drop", 32'(icache_ready), 32'd0);
    chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    issue(ICOP_HIT_INV, 12'h010, 32'h1234_5010, 1'b1, 0, "hitinv_nomatch", got);
    issue(ICOP_FETCH, 12'h018, 32'h1FD0_0018, 1'b1, 0, "kept_hit", got);
    issue(ICOP_HIT_INV, 12'h000, 32'h1C00_0000, 1'b1, 0, "hitinv_match", got);
    issue(ICOP_FETCH, 12'h000, 32'h1C00_0000, 1'b1, 0, "refetch_miss", got);
    issue(ICOP_IDX_INV, 12'h010, 32'h0000_0000, 1'b1, 0, "idx_inv", got);
    issue(ICOP_FETCH, 12'h01C, 32'h1FD0_001C, 1'b1, 0, "post_idxinv_miss", got);
    issue(ICOP_FETCH, 12'h000, 32'h1C00_1000, 1'b1, 0, "conflict_miss", got);
    issue(ICOP_FETCH, 12'h000, 32'h1C00_0000, 1'b1, 0, "conflict_back", got);
    issue(ICOP_FETCH, 12'hFF4, 32'h1C00_0FF4, 1'b1, 0, "top_set_miss", got);
    issue(ICOP_IDX_INIT, 12'hFF0, 32'hABCD_E000, 1'b1, 0, "idx_init", got);
    issue(ICOP_FETCH, 12'hFF8, 32'h1C00_0FF8, 1'b1, 0, "post_init_miss", got);

    // reset in the middle of a refill, after two beats
    beat_limit = 2;
    b0 = beats_sent;
    mreq_exp = 1'b1; mreq_addr = 32'h1C00_1020; mreq_burst = 1'b1;
    icache_op = ICOP_FETCH; icache_idx = 12'h020; icache_pa = 32'h1C00_1020; icache_is_cached = 1'b1;
    @(posedge clk); #1;
    icache_op = ICOP_NOP;
    t = 0;
    while (beats_sent < b0 + 2 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("abort_two_beats", 32'(beats_sent - b0), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("mid_refill_rst");
    for (int s = 0; s < 256; s++) mvalid[s] = 1'b0;
    mreq_exp = 1'b0;
    exp_q.delete();
    beat_limit = 4;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(ICOP_FETCH, 12'h020, 32'h1C00_1020, 1'b1, 0, "after_rst_miss", got);
    issue(ICOP_FETCH, 12'h000, 32'h1C00_0000, 1'b1, 0, "after_rst_cleared", got);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
